// File: rtl/snax_alu_v2_shell_wrapper.sv
// SNAX ALU v2 shell: NumPE signed lanes joined from two streamer inputs,
// one registered 2*DataWidth result stream, CSR-launched beat-counted jobs.
//
// state | meaning
// IDLE  | accepting CSR writes; a nonzero length launches a job
// RUN   | issuing/draining beats until the length-th output handshake
module snax_alu_v2_shell_wrapper #(
   parameter int NumPE        = 4,
   parameter int DataWidth    = 64,
   parameter int RegDataWidth = 32,
   parameter int RegRWCount   = 2,
   parameter int RegROCount   = 3
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic [NumPE*DataWidth-1:0]           stream2acc_0_data_i,
   input  logic                                 stream2acc_0_valid_i,
   output logic                                 stream2acc_0_ready_o,
   input  logic [NumPE*DataWidth-1:0]           stream2acc_1_data_i,
   input  logic                                 stream2acc_1_valid_i,
   output logic                                 stream2acc_1_ready_o,
   output logic [NumPE*2*DataWidth-1:0]         acc2stream_0_data_o,
   output logic                                 acc2stream_0_valid_o,
   input  logic                                 acc2stream_0_ready_i,
   input  logic [RegRWCount*RegDataWidth-1:0]   csr_reg_set_i,
   input  logic                                 csr_reg_set_valid_i,
   output logic                                 csr_reg_set_ready_o,
   output logic [RegROCount*RegDataWidth-1:0]   csr_reg_ro_set_o
);

   localparam int ResWidth = 2 * DataWidth;

   typedef enum logic {IDLE, RUN} state_t;

   state_t                       state;
   logic [2:0]                   mode;
   logic [RegDataWidth-1:0]      length;
   logic [RegDataWidth-1:0]      issued;
   logic [RegDataWidth-1:0]      busy_cnt;
   logic [RegDataWidth-1:0]      beat_cnt;
   logic                         out_valid;
   logic [NumPE*ResWidth-1:0]    out_data;
   logic [NumPE*ResWidth-1:0]    result;
   logic [RegDataWidth-1:0]      csr_length;
   logic                         busy;
   logic                         en;
   logic                         fire;
   logic                         out_hs;
   logic                         last_beat;
   logic                         unused_csr_bits;

   assign csr_length      = csr_reg_set_i[RegDataWidth +: RegDataWidth];
   assign unused_csr_bits = ^csr_reg_set_i[RegDataWidth-1:3];

   assign busy      = (state == RUN);
   assign en        = busy && (issued < length) && (!out_valid || acc2stream_0_ready_i);
   assign fire      = en && stream2acc_0_valid_i && stream2acc_1_valid_i;
   assign out_hs    = out_valid && acc2stream_0_ready_i;
   assign last_beat = (beat_cnt == length - 1'b1);

   assign stream2acc_0_ready_o = en && stream2acc_1_valid_i;
   assign stream2acc_1_ready_o = en && stream2acc_0_valid_i;
   assign csr_reg_set_ready_o  = !busy;
   assign acc2stream_0_valid_o = out_valid;
   assign acc2stream_0_data_o  = out_data;
   assign csr_reg_ro_set_o     = {beat_cnt, busy_cnt, {(RegDataWidth-1){1'b0}}, busy};

   // Operands are sign-extended to the result width first, so every mode is exact.
   for (genvar i = 0; i < NumPE; i++) begin : g_lane
      logic signed [DataWidth-1:0] a;
      logic signed [DataWidth-1:0] b;
      logic signed [ResWidth-1:0]  a_ext;
      logic signed [ResWidth-1:0]  b_ext;
      logic [ResWidth-1:0]         res;

      assign a     = stream2acc_0_data_i[i*DataWidth +: DataWidth];
      assign b     = stream2acc_1_data_i[i*DataWidth +: DataWidth];
      assign a_ext = ResWidth'(a);
      assign b_ext = ResWidth'(b);

      always_comb begin
         res = '0;
         case (mode)
            3'd0:    res = a_ext + b_ext;
            3'd1:    res = a_ext - b_ext;
            3'd2:    res = a_ext * b_ext;
            3'd3:    res = {{DataWidth{1'b0}}, a ^ b};
            3'd4:    res = (a > b) ? a_ext : b_ext;
            3'd5:    res = (a < b) ? a_ext : b_ext;
            default: res = '0;
         endcase
      end

      assign result[i*ResWidth +: ResWidth] = res;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         mode      <= '0;
         length    <= '0;
         issued    <= '0;
         busy_cnt  <= '0;
         beat_cnt  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (csr_reg_set_valid_i) begin
                  mode     <= csr_reg_set_i[2:0];
                  length   <= csr_length;
                  issued   <= '0;
                  busy_cnt <= '0;
                  beat_cnt <= '0;
                  if (csr_length != '0) state <= RUN;
               end
            end
            RUN: begin
               if (busy_cnt != '1) busy_cnt <= busy_cnt + 1'b1;
               if (out_hs) beat_cnt <= beat_cnt + 1'b1;
               if (out_hs && last_beat) state <= IDLE;
               if (fire) issued <= issued + 1'b1;
            end
            default: state <= IDLE;
         endcase

         // Output slot only reloads when it is empty or draining this cycle.
         if (fire) begin
            out_valid <= 1'b1;
            out_data  <= result;
         end else if (out_hs) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/snax_alu_v2_shell_wrapper.md
# snax_alu_v2_shell_wrapper

Second-generation SNAX ALU accelerator shell: NumPE parallel lanes with a wider mode set, operating on two streamer input channels and one streamer output channel. It runs CSR-launched jobs of a programmed beat count through a start/busy FSM and exposes busy and performance status to the CSR manager. It sits between the SNAX streamer and the CSR manager, replacing the first-generation ALU shell, with correctly packed 2×DataWidth output lanes.

## Interface
- NumPE, 4: parallel lanes per beat.
- DataWidth, 64: operand width per lane. Result lane is 2*DataWidth.
- RegDataWidth, 32: CSR word width. Also the width of the length and counter registers.
- RegRWCount, 2: RW CSRs. 0 = mode[2:0]; 1 = length in beats.
- RegROCount, 3: RO CSRs. 0 = busy (bit 0); 1 = busy-cycle count; 2 = completed output beats.

Ports:
- clk_i  in  1  clock. Clock is one domain, clk_i; reset is rst_i, synchronous, active-high.
- rst_i  in  1  synchronous active-high reset.
- stream2acc_0_data_i  in  NumPE*DataWidth  operand A; lane i = bits [i*DataWidth +: DataWidth].
- stream2acc_0_valid_i  in  1  A valid.
- stream2acc_0_ready_o  out  1  A ready.
- stream2acc_1_data_i  in  NumPE*DataWidth  operand B; same lane packing as A.
- stream2acc_1_valid_i  in  1  B valid.
- stream2acc_1_ready_o  out  1  B ready.
- acc2stream_0_data_o  out  NumPE*2*DataWidth  result; lane i = bits [i*2*DataWidth +: 2*DataWidth].
- acc2stream_0_valid_o  out  1  result valid.
- acc2stream_0_ready_i  in  1  result ready.
- csr_reg_set_i  in  RegRWCount×RegDataWidth  RW CSR values.
- csr_reg_set_valid_i  in  1  CSR write/launch strobe.
- csr_reg_set_ready_o  out  1  CSR write accepted.
- csr_reg_ro_set_o  out  RegROCount×RegDataWidth  RO status.

## Operation
- FSM states: IDLE, RUN.
- IDLE:
  - csr_reg_set_ready_o = 1.
  - On set handshake, latch mode and length, and clear both counters.
  - length ≠ 0 → RUN. length = 0 → stay IDLE (no-op).
- RUN:
  - csr_reg_set_ready_o = 0; busy = 1.
  - Go to IDLE in the cycle after the output handshake of beat number length.
- Input join:
  - en = RUN & issued < length & (!acc2stream_0_valid_o | acc2stream_0_ready_i).
  - stream2acc_0_ready_o = en & stream2acc_1_valid_i.
  - stream2acc_1_ready_o = en & stream2acc_0_valid_i.
  - fire = en & both valid. Both inputs are consumed together on fire; issued increments on fire.
- Modes (operands are signed two's complement; every lane uses the same mode):
  - 0 add: a+b.
  - 1 sub: a−b.
  - 2 mul: full signed product.
  - 3 xor: a^b, zero-extended.
  - 4 max: signed max of a and b.
  - 5 min: signed min of a and b.
  - 6, 7: result 0.
- Result width: add, sub, max and min are computed at DataWidth+1 bits where needed, then sign-extended to 2*DataWidth. No overflow is possible.
- Counters:
  - RO1 increments every cycle in RUN and saturates at all-ones.
  - RO2 increments on each output handshake.
  - Both hold their values in IDLE until the next launch.
- A CSR write is not accepted during RUN. It waits with valid held; there is no drop or queue.

## Timing
- Reset values:
  - all ready/valid outputs 0, except csr_reg_set_ready_o = 1 (IDLE).
  - acc2stream_0_data_o = 0; all RO CSRs = 0; mode = 0, length = 0.
- Latency: a fire in cycle t gives acc2stream_0_valid_o = 1 in cycle t+1, with the registered result.
- Throughput: one beat per cycle while the sink holds ready. Input ready depends combinationally on acc2stream_0_ready_i.
- Output register: holds data and valid stable while valid & !ready. Valid drops the cycle after a handshake with no new fire.
- Busy:
  - rises the cycle after launch.
  - falls the cycle after the last output handshake; csr_reg_set_ready_o returns to 1 in that same cycle.
- rst_i mid-job:
  - the next edge returns to IDLE and clears pipeline valid, counters and latched CSRs.
  - an in-flight result is discarded.
- Inputs presented in IDLE, or beyond length in RUN, see ready = 0 and are not consumed.

## Test plan
- Add, NumPE=4, DataWidth=64, length=3; A lanes = {1, −1, 0x7FFF…F, 5}, B lanes = {2, −1, 1, −7} → output lanes {3, −2, 0x8000…0 zero-upper, −2 sign-extended}. Exactly 3 beats out, then busy=0 and RO2=3.
- Mul mode, A = −3 and B = 0x8000…0 in every lane → each 128-bit lane = 0x0001…_8000…0 (the exact signed product). Xor mode gives a zero-extended upper half.
- Output backpressure: acc2stream_0_ready_i=0 for 5 cycles mid-job → data and valid held stable, both input readies 0. A beat count of 4 is preserved with no loss or duplication.
- Join skew: stream 0 valid 3 cycles before stream 1 → no fire until both are valid; stream 1 ready is high only while stream 0 is valid.
- CSR behaviour: launch with length=0 → no busy and no outputs. A launch attempt during RUN sees ready=0 and takes effect only after busy falls. A job of length=2 with no stalls gives RO1=3.
- Reset mid-job after 2 of 6 beats → next cycle all valids 0, RO CSRs 0, csr_reg_set_ready_o=1. A new job then runs cleanly.
